// File: rtl/tff_cell.sv
// tff_cell: single-bit toggle flip-flop cell for ripple counters and
// accumulators. Rising edges on WE flip the stored bit, a 1->0 flip emits a
// one-cycle carry pulse for the next stage, and RE gates the stored bit onto
// out. WE and RE may be asynchronous to clk and pass through SYNC_STAGES-deep
// synchronizer chains before use.
//
// Handshake/timing contract: WE is an edge-triggered request with no
// acknowledge; its high and low phases must each last at least two clk
// periods for every edge to be seen. RE is a level with no handshake; out
// follows it SYNC_STAGES edges later. carry is a registered pulse exactly one
// clk wide, launched on the same edge that clears the stored bit.
//
// The stored bit is brought out on dbg_state_o so checkers can observe it
// directly without waiting for a read.

module tff_cell #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic WE,
    input  logic RE,
    output logic out,
    output logic carry,
    output logic dbg_state_o
);

    // Synchronizer chains: index 0 samples the raw input, the highest index
    // is the synchronized value used by the core logic.
    logic [SYNC_STAGES-1:0] we_sync_q;
    logic [SYNC_STAGES-1:0] we_sync_d;
    logic [SYNC_STAGES-1:0] re_sync_q;
    logic [SYNC_STAGES-1:0] re_sync_d;

    // Previous synchronized WE, used for rising-edge detection.
    logic we_dly_q;
    logic we_dly_d;

    // Stored bit and output registers.
    logic state_q;
    logic state_d;
    logic carry_q;
    logic carry_d;
    logic out_q;
    logic out_d;

    // Synchronized views of the inputs and the derived toggle request.
    logic we_s;
    logic re_s;
    logic we_rise;

    // Next-state logic: shift the chains, detect WE rising, toggle the bit,
    // and build the carry and gated read-out from the pre-edge stored bit.
    always_comb begin
        we_sync_d = we_sync_q;
        re_sync_d = re_sync_q;
        we_sync_d[0] = WE;
        re_sync_d[0] = RE;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            we_sync_d[i] = we_sync_q[i-1];
            re_sync_d[i] = re_sync_q[i-1];
        end

        we_s    = we_sync_q[SYNC_STAGES-1];
        re_s    = re_sync_q[SYNC_STAGES-1];
        we_rise = we_s & ~we_dly_q;

        we_dly_d = we_s;
        // A toggle from 1 means the bit wraps to 0, which is the carry out.
        state_d  = state_q ^ we_rise;
        carry_d  = we_rise & state_q;
        // Read-out uses the stored bit before this edge's toggle.
        out_d    = re_s & state_q;
    end

    // State registers with asynchronous active-low clear; reset discards any
    // in-flight synchronizer contents so no stale toggle survives it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            we_sync_q <= '0;
            re_sync_q <= '0;
            we_dly_q  <= 1'b0;
            state_q   <= 1'b0;
            carry_q   <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            we_sync_q <= we_sync_d;
            re_sync_q <= re_sync_d;
            we_dly_q  <= we_dly_d;
            state_q   <= state_d;
            carry_q   <= carry_d;
            out_q     <= out_d;
        end
    end

    assign out         = out_q;
    assign carry       = carry_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tff_cell.sv
// Bench for tff_cell with the default two-stage synchronizers.

module tb_tff_cell;

    localparam int S = 2;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstb = 1'b0;
    logic we_i = 1'b0;
    logic re_i = 1'b0;
    logic dut_out;
    logic dut_carry;
    logic dut_state;

    always #5 clk = ~clk;

    tff_cell #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .WE          (we_i),
        .RE          (re_i),
        .out         (dut_out),
        .carry       (dut_carry),
        .dbg_state_o (dut_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // Keeps the per-edge samples of WE and RE. A toggle happens at the edge
    // where the sample taken S edges earlier is high and the one before it
    // is low; the stored bit is the parity of the toggle count and a carry
    // accompanies every even-numbered toggle (the 1->0 ones).
    logic we_h[$];
    logic re_h[$];
    int   m_toggles = 0;
    logic m_state   = 1'b0;
    logic m_carry   = 1'b0;
    logic m_out     = 1'b0;

    function automatic logic past(input logic q[$], input int back);
        int idx;
        idx = q.size() - 1 - back;
        if (idx < 0) return 1'b0;
        return q[idx];
    endfunction

    task automatic model_clear();
        we_h.delete();
        re_h.delete();
        m_toggles = 0;
        m_state   = 1'b0;
        m_carry   = 1'b0;
        m_out     = 1'b0;
    endtask

    task automatic model_edge();
        if (rstb) begin
            we_h.push_back(we_i);
            re_h.push_back(re_i);
            m_out   = past(re_h, S) & m_state;
            m_carry = 1'b0;
            if (past(we_h, S) && !past(we_h, S + 1)) begin
                m_toggles++;
                m_state = (m_toggles % 2) == 1;
                m_carry = (m_toggles % 2) == 0;
            end
            if (we_h.size() > 16) begin
                void'(we_h.pop_front());
                void'(re_h.pop_front());
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are sampled on the next
    // falling edge, after the rising edge has been modelled.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic re);
        we_i = we;
        re_i = re;
        tick();
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " out"}, dut_out, m_out);
        check({tag, " carry"}, dut_carry, m_carry);
        check({tag, " state"}, dut_state, m_state);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out"}, dut_out, 1'b0);
        check({tag, " carry"}, dut_carry, 1'b0);
        check({tag, " state"}, dut_state, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic we;
        logic re;
        logic st;
        logic cy;
        logic o;
    } vec_t;

    vec_t tbl[14];

    // ---------------- test sequence ----------------
    initial begin
        logic wv;
        logic rv;
        int   run;

        // Single write then read, then a second write during the read.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with RE high and WE toggling.
        model_clear();
        rstb = 1'b0;
        re_i = 1'b1;
        #1;
        check_zero("reset_initial");
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(((i / 2) % 2) == 0, 1'b1);
            check_zero("reset_held");
        end

        // Release with WE low and RE high: nothing stored, so out stays 0.
        rstb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1);
            check_zero("post_release");
        end

        // Table: single write, read, second write with carry.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].we, tbl[i].re);
            check($sformatf("tbl[%0d] state", i), dut_state, tbl[i].st);
            check($sformatf("tbl[%0d] carry", i), dut_carry, tbl[i].cy);
            check($sformatf("tbl[%0d] out", i), dut_out, tbl[i].o);
        end

        // WE held high for 20 cycles: exactly one toggle, no carry.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0);
            check("held_we carry", dut_carry, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0);
            check("held_we carry_after", dut_carry, 1'b0);
        end
        check("held_we state", dut_state, 1'b1);

        // Read gating with state=1: RE high 5 cycles then low.
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, i < 5);
            check($sformatf("read_gate[%0d] out", i), dut_out, (i >= 2) && (i <= 6));
            check("read_gate state", dut_state, 1'b1);
        end

        // Reset mid-toggle: clean start, WE rises, reset hits before the toggle.
        rstb = 1'b0;
        model_clear();
        #1;
        check_zero("reset2_assert");
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0);
        end
        drive(1'b1, 1'b0);
        rstb = 1'b0;
        we_i = 1'b0;
        model_clear();
        #1;
        check_zero("mid_toggle_reset");
        @(negedge clk);
        tick();
        rstb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1);
            check_zero("mid_toggle_after");
        end

        // Randomized runs against the model, with occasional resets.
        wv = 1'b0;
        rv = 1'b0;
        run = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rstb = 1'b0;
                model_clear();
                #1;
                check_zero("rand_reset");
                @(negedge clk);
                tick();
                rstb = 1'b1;
            end
            if (run == 0) begin
                wv = ~wv;
                run = $urandom_range(1, 6);
            end
            run--;
            if ($urandom_range(0, 3) == 0) rv = $urandom_range(0, 1);
            drive(wv, rv);
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
